// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared encodings for the Titan multi-cycle control sequencer
//   opcodes, R-type functs, aluOp/pcSrc/wbSel encodings and the FSM state type
package control_fsm_pkg;
    localparam int OPBITS    = 4;
    localparam int FUNCTBITS = 4;
    localparam int ALUOPBITS = 4;

    localparam logic [OPBITS-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPBITS-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPBITS-1:0] OP_ANDI  = 4'h2;
    localparam logic [OPBITS-1:0] OP_ORI   = 4'h3;
    localparam logic [OPBITS-1:0] OP_LW    = 4'h4;
    localparam logic [OPBITS-1:0] OP_SW    = 4'h5;
    localparam logic [OPBITS-1:0] OP_BEQ   = 4'h6;
    localparam logic [OPBITS-1:0] OP_BNE   = 4'h7;
    localparam logic [OPBITS-1:0] OP_J     = 4'h8;
    localparam logic [OPBITS-1:0] OP_JAL   = 4'h9;
    localparam logic [OPBITS-1:0] OP_HALT  = 4'hF;

    localparam logic [FUNCTBITS-1:0] FN_ADD = 4'h0;
    localparam logic [FUNCTBITS-1:0] FN_SUB = 4'h1;
    localparam logic [FUNCTBITS-1:0] FN_AND = 4'h2;
    localparam logic [FUNCTBITS-1:0] FN_OR  = 4'h3;
    localparam logic [FUNCTBITS-1:0] FN_XOR = 4'h4;
    localparam logic [FUNCTBITS-1:0] FN_SLL = 4'h5;
    localparam logic [FUNCTBITS-1:0] FN_SRL = 4'h6;
    localparam logic [FUNCTBITS-1:0] FN_SLT = 4'h7;

    // ALU_NOP is what the ALU sees outside EXEC, so ADD is kept distinct from it
    localparam logic [ALUOPBITS-1:0] ALU_NOP = 4'h0;
    localparam logic [ALUOPBITS-1:0] ALU_ADD = 4'h1;
    localparam logic [ALUOPBITS-1:0] ALU_SUB = 4'h2;
    localparam logic [ALUOPBITS-1:0] ALU_AND = 4'h3;
    localparam logic [ALUOPBITS-1:0] ALU_OR  = 4'h4;
    localparam logic [ALUOPBITS-1:0] ALU_XOR = 4'h5;
    localparam logic [ALUOPBITS-1:0] ALU_SLL = 4'h6;
    localparam logic [ALUOPBITS-1:0] ALU_SRL = 4'h7;
    localparam logic [ALUOPBITS-1:0] ALU_SLT = 4'h8;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: decoder/ALU/memory-handshake bundle of the control sequencer
//   master = sequencer side (takes opCode/functCode/zero/memAck, drives enables)
//   slave  = datapath/memory side
interface control_fsm_if;
    import control_fsm_pkg::*;
    logic [OPBITS-1:0]    opCode;
    logic [FUNCTBITS-1:0] functCode;
    logic                 zero;
    logic                 memAck;
    logic                 memReq;
    logic                 memWe;
    logic                 iorD;
    logic                 irWrite;
    logic                 pcWrite;
    logic [1:0]           pcSrc;
    logic                 regWrite;
    logic                 regDstSel;
    logic [1:0]           wbSel;
    logic                 aluSrcB;
    logic [ALUOPBITS-1:0] aluOp;
    logic                 halted;
    logic                 illegal;
    modport master (
        input  opCode, functCode, zero, memAck,
        output memReq, memWe, iorD, irWrite, pcWrite, pcSrc, regWrite, regDstSel,
               wbSel, aluSrcB, aluOp, halted, illegal
    );
    modport slave (
        output opCode, functCode, zero, memAck,
        input  memReq, memWe, iorD, irWrite, pcWrite, pcSrc, regWrite, regDstSel,
               wbSel, aluSrcB, aluOp, halted, illegal
    );
endinterface

// File: rtl/control_fsm_alu_op_decode.sv
// control_fsm_alu_op_decode: combinational {opCode, functCode} -> {aluOp, aluSrcB, legal}
//   op_i/funct_i in; alu_op_o, alu_src_b_o (1 = immediate), legal_o out
module control_fsm_alu_op_decode
    import control_fsm_pkg::*;
(
    input  logic [OPBITS-1:0]    op_i,
    input  logic [FUNCTBITS-1:0] funct_i,
    output logic [ALUOPBITS-1:0] alu_op_o,
    output logic                 alu_src_b_o,
    output logic                 legal_o
);
    always_comb begin
        alu_op_o    = ALU_NOP;
        alu_src_b_o = 1'b0;
        legal_o     = 1'b1;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_XOR:  alu_op_o = ALU_XOR;
                    FN_SLL:  alu_op_o = ALU_SLL;
                    FN_SRL:  alu_op_o = ALU_SRL;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    default: legal_o  = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_op_o    = ALU_ADD;
                alu_src_b_o = 1'b1;
            end
            OP_ANDI: begin
                alu_op_o    = ALU_AND;
                alu_src_b_o = 1'b1;
            end
            OP_ORI: begin
                alu_op_o    = ALU_OR;
                alu_src_b_o = 1'b1;
            end
            OP_BEQ, OP_BNE: alu_op_o = ALU_SUB;
            OP_J, OP_JAL, OP_HALT: legal_o = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle Titan control sequencer (FETCH/DECODE/EXEC/MEM/WB, halt on HALT/illegal)
//   clk, reset (async, active-high); bus = control_fsm_if.master carrying decoder inputs,
//   ALU zero, memory handshake and all datapath enables
module control_fsm
    import control_fsm_pkg::*;
(
    input logic           clk,
    input logic           reset,
    control_fsm_if.master bus
);
    state_t               state_q, state_d;
    logic [OPBITS-1:0]    op_q, dec_op;
    logic [FUNCTBITS-1:0] funct_q, dec_funct;
    logic                 halted_q, halted_d, illegal_q, illegal_d;
    logic [ALUOPBITS-1:0] dec_alu_op;
    logic                 dec_src_b, dec_legal;

    // One decoder serves both DECODE (live opcode, for legality) and later states (latched opcode)
    assign dec_op    = (state_q == S_DECODE) ? bus.opCode : op_q;
    assign dec_funct = (state_q == S_DECODE) ? bus.functCode : funct_q;

    control_fsm_alu_op_decode u_dec (
        .op_i        (dec_op),
        .funct_i     (dec_funct),
        .alu_op_o    (dec_alu_op),
        .alu_src_b_o (dec_src_b),
        .legal_o     (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_START;
            op_q      <= '0;
            funct_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            if (state_q == S_DECODE) begin
                op_q    <= bus.opCode;
                funct_q <= bus.functCode;
            end
        end
    end

    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        illegal_d     = illegal_q;
        bus.memReq    = 1'b0;
        bus.memWe     = 1'b0;
        bus.iorD      = 1'b0;
        bus.irWrite   = 1'b0;
        bus.pcWrite   = 1'b0;
        bus.pcSrc     = PC_INC;
        bus.regWrite  = 1'b0;
        bus.regDstSel = 1'b0;
        bus.wbSel     = WB_ALU;
        bus.aluSrcB   = 1'b0;
        bus.aluOp     = ALU_NOP;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                bus.memReq  = 1'b1;
                bus.irWrite = bus.memAck;
                bus.pcWrite = bus.memAck;
                state_d     = bus.memAck ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else if (dec_op == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (dec_op == OP_J || dec_op == OP_JAL) begin
                    // PC+1 is still in the PC here, so JAL links it in the same cycle as the jump
                    bus.pcWrite   = 1'b1;
                    bus.pcSrc     = PC_JUMP;
                    bus.regWrite  = dec_op == OP_JAL;
                    bus.regDstSel = dec_op == OP_JAL;
                    bus.wbSel     = (dec_op == OP_JAL) ? WB_PC : WB_ALU;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.aluOp   = dec_alu_op;
                bus.aluSrcB = dec_src_b;
                if (op_q == OP_BEQ || op_q == OP_BNE) begin
                    bus.pcWrite = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
                    bus.pcSrc   = PC_BRANCH;
                    state_d     = S_FETCH;
                end else begin
                    state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                bus.memReq = 1'b1;
                bus.iorD   = 1'b1;
                bus.memWe  = op_q == OP_SW;
                if (bus.memAck) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.regWrite = 1'b1;
                bus.wbSel    = (op_q == OP_LW) ? WB_MEM : WB_ALU;
                state_d      = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed scoreboard bench for control_fsm
module tb_control_fsm;
    import control_fsm_pkg::*;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       regWrite;
        logic       regDstSel;
        logic [1:0] wbSel;
        logic       aluSrcB;
        logic [3:0] aluOp;
        logic       halted;
        logic       illegal;
    } out_t;

    typedef struct {
        string name;
        out_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    out_t act;

    control_fsm_if bus ();

    control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign act = {bus.memReq, bus.memWe, bus.iorD, bus.irWrite, bus.pcWrite, bus.pcSrc,
                  bus.regWrite, bus.regDstSel, bus.wbSel, bus.aluSrcB, bus.aluOp,
                  bus.halted, bus.illegal};

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.v);
            end
        end
    end

    function automatic out_t o_fetch(input logic ack);
        out_t o = '0;
        o.memReq  = 1'b1;
        o.irWrite = ack;
        o.pcWrite = ack;
        return o;
    endfunction

    function automatic out_t o_exec(input logic [3:0] op, input logic srcb, input logic pcw,
                                    input logic [1:0] src);
        out_t o = '0;
        o.aluOp   = op;
        o.aluSrcB = srcb;
        o.pcWrite = pcw;
        o.pcSrc   = src;
        return o;
    endfunction

    function automatic out_t o_mem(input logic we);
        out_t o = '0;
        o.memReq = 1'b1;
        o.iorD   = 1'b1;
        o.memWe  = we;
        return o;
    endfunction

    function automatic out_t o_wb(input logic [1:0] sel);
        out_t o = '0;
        o.regWrite = 1'b1;
        o.wbSel    = sel;
        return o;
    endfunction

    function automatic out_t o_jump(input logic link);
        out_t o = '0;
        o.pcWrite   = 1'b1;
        o.pcSrc     = 2'd2;
        o.regWrite  = link;
        o.regDstSel = link;
        o.wbSel     = link ? 2'd2 : 2'd0;
        return o;
    endfunction

    function automatic out_t o_halt(input logic ill);
        out_t o = '0;
        o.halted  = 1'b1;
        o.illegal = ill;
        return o;
    endfunction

    task automatic step(input string name, input out_t e, input logic ack, input logic z);
        exp_t x;
        bus.memAck = ack;
        bus.zero   = z;
        x.name     = name;
        x.v        = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [3:0] f);
        bus.opCode    = op;
        bus.functCode = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("reset", '0, 1'b1, 1'b0);
        step("reset", '0, 1'b0, 1'b0);
        reset = 1'b0;
        step("start", '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.opCode    = '0;
        bus.functCode = '0;
        bus.memAck    = 1'b0;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        set_instr(OP_RTYPE, 4'h0);
        step("add_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("add_decode", '0, 1'b1, 1'b0);
        step("add_exec", o_exec(ALU_ADD, 1'b0, 1'b0, 2'd0), 1'b1, 1'b0);
        step("add_wb", o_wb(2'd0), 1'b1, 1'b0);

        set_instr(OP_LW, 4'h0);
        for (int i = 0; i < 3; i++) step("lw_fetch_wait", o_fetch(1'b0), 1'b0, 1'b0);
        step("lw_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("lw_decode", '0, 1'b0, 1'b0);
        step("lw_exec", o_exec(ALU_ADD, 1'b1, 1'b0, 2'd0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", o_mem(1'b0), 1'b0, 1'b0);
        step("lw_mem", o_mem(1'b0), 1'b1, 1'b0);
        step("lw_wb", o_wb(2'd1), 1'b0, 1'b0);

        set_instr(OP_BEQ, 4'h0);
        step("beq_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("beq_decode", '0, 1'b1, 1'b1);
        step("beq_exec_z1", o_exec(ALU_SUB, 1'b0, 1'b1, 2'd1), 1'b1, 1'b1);
        step("beq2_fetch", o_fetch(1'b1), 1'b1, 1'b1);
        step("beq2_decode", '0, 1'b1, 1'b0);
        step("beq_exec_z0", o_exec(ALU_SUB, 1'b0, 1'b0, 2'd1), 1'b1, 1'b0);

        set_instr(OP_BNE, 4'h0);
        step("bne_fetch", o_fetch(1'b1), 1'b1, 1'b1);
        step("bne_decode", '0, 1'b1, 1'b1);
        step("bne_exec_z1", o_exec(ALU_SUB, 1'b0, 1'b0, 2'd1), 1'b1, 1'b1);
        step("bne2_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("bne2_decode", '0, 1'b1, 1'b0);
        step("bne_exec_z0", o_exec(ALU_SUB, 1'b0, 1'b1, 2'd1), 1'b1, 1'b0);

        set_instr(OP_SW, 4'h0);
        step("sw_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("sw_decode", '0, 1'b1, 1'b0);
        step("sw_exec", o_exec(ALU_ADD, 1'b1, 1'b0, 2'd0), 1'b1, 1'b0);
        step("sw_mem", o_mem(1'b1), 1'b1, 1'b0);

        set_instr(OP_ORI, 4'h0);
        step("ori_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("ori_decode", '0, 1'b1, 1'b0);
        step("ori_exec", o_exec(ALU_OR, 1'b1, 1'b0, 2'd0), 1'b1, 1'b0);
        step("ori_wb", o_wb(2'd0), 1'b1, 1'b0);

        set_instr(OP_ANDI, 4'h0);
        step("andi_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("andi_decode", '0, 1'b1, 1'b0);
        step("andi_exec", o_exec(ALU_AND, 1'b1, 1'b0, 2'd0), 1'b1, 1'b0);
        step("andi_wb", o_wb(2'd0), 1'b1, 1'b0);

        set_instr(OP_RTYPE, 4'h7);
        step("slt_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("slt_decode", '0, 1'b1, 1'b0);
        step("slt_exec", o_exec(ALU_SLT, 1'b0, 1'b0, 2'd0), 1'b1, 1'b0);
        step("slt_wb", o_wb(2'd0), 1'b1, 1'b0);

        set_instr(OP_J, 4'h0);
        step("j_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("j_decode", o_jump(1'b0), 1'b1, 1'b0);

        set_instr(OP_JAL, 4'h0);
        step("jal_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("jal_decode", o_jump(1'b1), 1'b1, 1'b0);
        step("jal_next_fetch", o_fetch(1'b0), 1'b0, 1'b0);
        step("jal_next_fetch_ack", o_fetch(1'b1), 1'b1, 1'b0);

        set_instr(OP_LW, 4'h0);
        step("lwr_decode", '0, 1'b0, 1'b0);
        step("lwr_exec", o_exec(ALU_ADD, 1'b1, 1'b0, 2'd0), 1'b0, 1'b0);
        step("lwr_mem_wait", o_mem(1'b0), 1'b0, 1'b0);
        reset = 1'b1;
        step("reset_in_mem", '0, 1'b0, 1'b0);
        step("reset_hold", '0, 1'b0, 1'b0);
        reset = 1'b0;
        step("start_after_mem_reset", '0, 1'b0, 1'b0);
        step("refetch", o_fetch(1'b0), 1'b0, 1'b0);

        do_reset();
        set_instr(4'hA, 4'h0);
        step("illop_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("illop_decode", '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("illop_halt", o_halt(1'b1), 1'b1, 1'b0);

        do_reset();
        set_instr(OP_RTYPE, 4'hC);
        step("illfn_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("illfn_decode", '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("illfn_halt", o_halt(1'b1), 1'b1, 1'b0);

        do_reset();
        set_instr(OP_HALT, 4'h0);
        step("halt_fetch", o_fetch(1'b1), 1'b1, 1'b0);
        step("halt_decode", '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("halt_state", o_halt(1'b0), 1'b1, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
